// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit and its prefetch buffer.
package ifu_pkg;

    localparam int INST_ADDR_BUS_W = 32;
    localparam int INST_BUS_W      = 32;

    typedef logic [INST_ADDR_BUS_W-1:0] inst_addr_bus_t;
    typedef logic [INST_BUS_W-1:0]      inst_bus_t;

    // addi x0, x0, 0 -- what the decoder sees whenever no real instruction is offered
    localparam inst_bus_t      INST_NOP       = 32'h0000_0013;
    localparam inst_addr_bus_t INST_ADDR_ZERO = '0;

    // Sequential fetch stride in bytes
    localparam inst_addr_bus_t PC_STEP = 32'd4;

    // One prefetch buffer entry: the word and the address it was fetched from
    typedef struct packed {
        inst_addr_bus_t addr;
        inst_bus_t      inst;
    } fetch_entry_t;

    localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

    // Redirect targets are forced onto a word boundary; the low two bits are don't-care
    function automatic inst_addr_bus_t word_align(input inst_addr_bus_t addr);
        return addr & ~inst_addr_bus_t'(3);
    endfunction

endpackage

// File: rtl/ifu_sync_fifo.sv
// Generic synchronous FIFO with registered storage, occupancy count and a one-cycle flush.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    logic do_push;
    logic do_pop;

    assign full  = (count_q == DEPTH_CNT);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // A push into a full FIFO is only legal when the head leaves in the same cycle
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    // Pointer, occupancy and storage update; flush discards every entry at once
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: owns the fetch PC, issues pipelined bus requests, buffers the
// in-order responses in a prefetch FIFO and flushes/redirects on a jump from execute.
module ifu
    import ifu_pkg::*;
#(
    parameter inst_addr_bus_t RESET_PC = 32'h0000_0000,
    parameter int             DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       rst,

    output logic                       ibus_req_o,
    output logic [INST_ADDR_BUS_W-1:0] ibus_addr_o,
    input  logic                       ibus_gnt_i,
    input  logic                       ibus_rvalid_i,
    input  logic [INST_BUS_W-1:0]      ibus_rdata_i,

    input  logic                       jump_flag_i,
    input  logic [INST_ADDR_BUS_W-1:0] jump_addr_i,

    output logic                       inst_valid_o,
    output logic [INST_BUS_W-1:0]      inst_o,
    output logic [INST_ADDR_BUS_W-1:0] inst_addr_o,
    input  logic                       inst_ready_i
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0] DEPTH_OCC = (CNT_W + 1)'(DEPTH);

    inst_addr_bus_t fetch_pc_q, fetch_pc_d;
    inst_addr_bus_t resp_pc_q,  resp_pc_d;
    logic [CNT_W-1:0] pending_q, pending_d;
    logic [CNT_W-1:0] drop_q,    drop_d;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_flush;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    fetch_entry_t     fifo_wdata;
    fetch_entry_t     fifo_rdata;

    logic             head_pop;
    logic [CNT_W:0]   occupancy;
    logic             grant;
    logic             rsp_accept;
    logic             rsp_drop;
    logic             rsp_keep;
    inst_addr_bus_t   jump_target;

    sync_fifo #(
        .WIDTH (FETCH_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (fifo_flush),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Downstream view of the FIFO head; idle outputs show a NOP at address zero
    always_comb begin
        inst_valid_o = !fifo_empty;
        inst_o       = INST_NOP;
        inst_addr_o  = INST_ADDR_ZERO;
        if (!fifo_empty) begin
            inst_o      = fifo_rdata.inst;
            inst_addr_o = fifo_rdata.addr;
        end
    end

    // Bus handshake decode: request only while buffered plus in-flight words still fit
    always_comb begin
        head_pop    = inst_valid_o && inst_ready_i;
        occupancy   = {1'b0, fifo_count} + {1'b0, pending_q} - {{CNT_W{1'b0}}, head_pop};
        ibus_req_o  = !rst && !jump_flag_i && (occupancy < DEPTH_OCC);
        ibus_addr_o = fetch_pc_q;
        grant       = ibus_req_o && ibus_gnt_i;
        rsp_accept  = ibus_rvalid_i && (pending_q != '0);
        rsp_drop    = rsp_accept && (drop_q != '0);
        rsp_keep    = rsp_accept && (drop_q == '0) && !jump_flag_i;
        jump_target = word_align(jump_addr_i);
    end

    // FIFO control: a redirect empties the buffer and overrides any push or pop
    always_comb begin
        fifo_flush      = jump_flag_i;
        fifo_pop        = head_pop && !jump_flag_i;
        fifo_push       = rsp_keep && (!fifo_full || fifo_pop);
        fifo_wdata.addr = resp_pc_q;
        fifo_wdata.inst = ibus_rdata_i;
    end

    // PC, in-flight and discard bookkeeping; a redirect drops everything still outstanding
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        pending_d  = pending_q + CNT_W'(grant) - CNT_W'(rsp_accept);
        drop_d     = drop_q;
        if (grant) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
        end
        if (rsp_drop) begin
            drop_d = drop_q - 1'b1;
        end
        if (rsp_keep) begin
            resp_pc_d = resp_pc_q + PC_STEP;
        end
        if (jump_flag_i) begin
            fetch_pc_d = jump_target;
            resp_pc_d  = jump_target;
            drop_d     = pending_d;
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            pending_q  <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            pending_q  <= pending_d;
            drop_q     <= drop_d;
        end
    end

endmodule
